issue_queue_ctrl: RTL

//  Controls a DEPTH-entry collapsing issue queue that holds entries in age order; entry 0 is the oldest.
//  - Accepts one dispatched instruction per cycle into the tail.
//  - Tracks operand readiness from writeback tag broadcasts.
//  - Selects the oldest ready entry and issues it to the single execute port.
//  - Compacts the queue so valid entries stay contiguous from entry 0.

---
 rtl/issue_queue_ctrl.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/issue_queue_ctrl.sv
// -----------------------------------------------------------------------------
// issue_queue_ctrl
//
// Purpose:
//   Control for a DEPTH-entry collapsing issue queue. Entries are held in age
//   order with entry 0 the oldest. Valid entries always occupy the contiguous
//   prefix [0, count-1]. The queue accepts one dispatch per cycle at the tail,
//   wakes source operands from writeback tag broadcasts, and issues the oldest
//   fully-ready entry to a single execute port. When an entry issues, the
//   younger entries slide down one slot to close the gap.
//
// Ports:
//   clk, rst_n          clock / asynchronous active-low reset
//   flush               synchronous squash of every entry (highest priority)
//   disp_valid/ready    dispatch handshake; disp_ready = (count < DEPTH)
//   disp_payload        opaque instruction payload
//   disp_s{1,2}_tag/rdy source tags and their already-available flags
//   wb_valid, wb_tag    writeback tag broadcast
//   iss_valid/ready     issue handshake to the execute port
//   iss_payload         payload of the selected (oldest eligible) entry
//   iss_slot            queue index of the selected entry
//   count               number of valid entries
// -----------------------------------------------------------------------------
module issue_queue_ctrl #(
    parameter int DEPTH     = 4,
    parameter int PAYLOAD_W = 32,
    parameter int TAG_W     = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       disp_valid,
    output logic                       disp_ready,
    input  logic [PAYLOAD_W-1:0]       disp_payload,
    input  logic [TAG_W-1:0]           disp_s1_tag,
    input  logic                       disp_s1_rdy,
    input  logic [TAG_W-1:0]           disp_s2_tag,
    input  logic                       disp_s2_rdy,
    input  logic                       wb_valid,
    input  logic [TAG_W-1:0]           wb_tag,
    output logic                       iss_valid,
    input  logic                       iss_ready,
    output logic [PAYLOAD_W-1:0]       iss_payload,
    output logic [$clog2(DEPTH)-1:0]   iss_slot,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int SLOT_W = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);

    // Per-entry state
    logic [DEPTH-1:0]     valid_q,  valid_d;
    logic [DEPTH-1:0]     s1_rdy_q, s1_rdy_d;
    logic [DEPTH-1:0]     s2_rdy_q, s2_rdy_d;
    logic [PAYLOAD_W-1:0] payload_q [DEPTH];
    logic [PAYLOAD_W-1:0] payload_d [DEPTH];
    logic [TAG_W-1:0]     s1_tag_q  [DEPTH];
    logic [TAG_W-1:0]     s1_tag_d  [DEPTH];
    logic [TAG_W-1:0]     s2_tag_q  [DEPTH];
    logic [TAG_W-1:0]     s2_tag_d  [DEPTH];
    logic [CNT_W-1:0]     count_q,  count_d;

    logic [DEPTH-1:0]     eligible;
    logic [SLOT_W-1:0]    sel_slot;
    logic                 any_elig;
    logic                 iss_fire;
    logic                 disp_fire;
    logic [CNT_W-1:0]     disp_idx;
    int                   src;

    // Eligibility looks only at registered state, so a wakeup this cycle
    // cannot make an entry issuable until the following cycle.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_elig
            assign eligible[gi] = valid_q[gi] & s1_rdy_q[gi] & s2_rdy_q[gi];
        end
    endgenerate

    // Oldest-first select: scanning downward leaves the lowest index last.
    always_comb begin
        sel_slot = '0;
        any_elig = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                sel_slot = SLOT_W'(i);
                any_elig = 1'b1;
            end
        end
    end

    assign iss_valid   = any_elig & ~flush;
    assign iss_slot    = sel_slot;
    assign iss_payload = any_elig ? payload_q[sel_slot] : '0;
    assign count       = count_q;

    // A full queue refuses dispatch even when an issue frees a slot this cycle.
    assign disp_ready  = (count_q < CNT_W'(DEPTH));

    assign iss_fire    = iss_valid & iss_ready;
    assign disp_fire   = disp_valid & disp_ready & ~flush;
    // The tail slides down by one when an issue fires alongside a dispatch.
    assign disp_idx    = count_q - CNT_W'(iss_fire);

    always_comb begin
        valid_d   = valid_q;
        s1_rdy_d  = s1_rdy_q;
        s2_rdy_d  = s2_rdy_q;
        payload_d = payload_q;
        s1_tag_d  = s1_tag_q;
        s2_tag_d  = s2_tag_q;
        count_d   = count_q;
        src       = 0;

        if (flush) begin
            valid_d  = '0;
            s1_rdy_d = '0;
            s2_rdy_d = '0;
            count_d  = '0;
        end else begin
            // Collapse: every entry at or above the issued slot takes its
            // younger neighbour; the top slot empties.
            if (iss_fire) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (i >= int'(sel_slot)) begin
                        src          = (i < DEPTH - 1) ? i + 1 : i;
                        valid_d[i]   = valid_q[src];
                        s1_rdy_d[i]  = s1_rdy_q[src];
                        s2_rdy_d[i]  = s2_rdy_q[src];
                        payload_d[i] = payload_q[src];
                        s1_tag_d[i]  = s1_tag_q[src];
                        s2_tag_d[i]  = s2_tag_q[src];
                        if (i == DEPTH - 1) begin
                            valid_d[i]  = 1'b0;
                            s1_rdy_d[i] = 1'b0;
                            s2_rdy_d[i] = 1'b0;
                        end
                    end
                end
            end

            if (disp_fire) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (disp_idx == CNT_W'(i)) begin
                        valid_d[i]   = 1'b1;
                        payload_d[i] = disp_payload;
                        s1_tag_d[i]  = disp_s1_tag;
                        s2_tag_d[i]  = disp_s2_tag;
                        s1_rdy_d[i]  = disp_s1_rdy;
                        s2_rdy_d[i]  = disp_s2_rdy;
                    end
                end
            end

            // Wakeup runs on the post-shift, post-dispatch image so moved
            // entries are woken and a same-cycle dispatch sees the bypass.
            if (wb_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_d[i] && (s1_tag_d[i] == wb_tag)) s1_rdy_d[i] = 1'b1;
                    if (valid_d[i] && (s2_tag_d[i] == wb_tag)) s2_rdy_d[i] = 1'b1;
                end
            end

            count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            s1_rdy_q <= '0;
            s2_rdy_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                payload_q[i] <= '0;
                s1_tag_q[i]  <= '0;
                s2_tag_q[i]  <= '0;
            end
        end else begin
            valid_q   <= valid_d;
            s1_rdy_q  <= s1_rdy_d;
            s2_rdy_q  <= s2_rdy_d;
            count_q   <= count_d;
            payload_q <= payload_d;
            s1_tag_q  <= s1_tag_d;
            s2_tag_q  <= s2_tag_d;
        end
    end

endmodule
